// File: rtl/mul_seq.sv
// Multi-cycle 8x8 unsigned multiply sequencer that borrows the shared 8-bit ALU.
// Idle: the core's ALU controls pass straight through. Busy: drives shift-and-add through the ALU.
module mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  mul_a,
    input  logic [7:0]  mul_b,
    output logic [15:0] prod,
    output logic        done,
    output logic        busy,
    output logic        stall,
    input  logic [3:0]  cpu_op,
    input  logic        cpu_right,
    input  logic [7:0]  cpu_ai,
    input  logic [7:0]  cpu_bi,
    input  logic        cpu_ci,
    input  logic        cpu_bcd,
    input  logic        cpu_rdy,
    output logic [3:0]  alu_op,
    output logic        alu_right,
    output logic [7:0]  alu_ai,
    output logic [7:0]  alu_bi,
    output logic        alu_ci,
    output logic        alu_bcd,
    output logic        alu_rdy,
    input  logic [7:0]  alu_out,
    input  logic        alu_co
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_RORH = 3'd2,
        ST_RORL = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_ROR = 4'b1111;

    state_t      state_r;
    logic [7:0]  ph_r;
    logic [7:0]  ml_r;
    logic [7:0]  mc_r;
    logic [2:0]  cnt_r;
    logic [15:0] prod_r;
    logic        done_r;
    logic        busy_r;
    logic [7:0]  hold_ai_r;
    logic        hold_ci_r;

    // Sequencer FSM, datapath registers and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ph_r      <= 8'h00;
            ml_r      <= 8'h00;
            mc_r      <= 8'h00;
            cnt_r     <= 3'd0;
            prod_r    <= 16'h0000;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            hold_ai_r <= 8'h00;
            hold_ci_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        ph_r    <= 8'h00;
                        ml_r    <= mul_b;
                        mc_r    <= mul_a;
                        cnt_r   <= 3'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_ADD;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    state_r <= ST_RORH;
                end
                ST_RORH: begin
                    ph_r    <= alu_out;
                    state_r <= ST_RORL;
                end
                ST_RORL: begin
                    // Remember the low-byte rotate so NEXT/DONE keep presenting it
                    ph_r      <= alu_out;
                    hold_ai_r <= ml_r;
                    hold_ci_r <= alu_co;
                    state_r   <= ST_NEXT;
                end
                ST_NEXT: begin
                    ml_r <= alu_out;
                    if (cnt_r == 3'd7) begin
                        // Product becomes visible together with the done pulse
                        prod_r  <= {ph_r, alu_out};
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + 3'd1;
                        state_r <= ST_ADD;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU control mux: passthrough while idle, sequencer-owned while busy
    always_comb begin
        alu_op    = cpu_op;
        alu_right = cpu_right;
        alu_ai    = cpu_ai;
        alu_bi    = cpu_bi;
        alu_ci    = cpu_ci;
        alu_bcd   = cpu_bcd;
        alu_rdy   = cpu_rdy;
        case (state_r)
            ST_IDLE: begin
                alu_op    = cpu_op;
                alu_right = cpu_right;
                alu_ai    = cpu_ai;
                alu_bi    = cpu_bi;
                alu_ci    = cpu_ci;
                alu_bcd   = cpu_bcd;
                alu_rdy   = cpu_rdy;
            end
            ST_ADD: begin
                // Add is always issued (zero addend) to keep iteration timing fixed
                alu_op    = OP_ADD;
                alu_right = 1'b0;
                alu_ai    = ph_r;
                alu_bi    = ml_r[0] ? mc_r : 8'h00;
                alu_ci    = 1'b0;
                alu_bcd   = 1'b0;
                alu_rdy   = 1'b1;
            end
            ST_RORH: begin
                alu_op    = OP_ROR;
                alu_right = 1'b1;
                alu_ai    = alu_out;
                alu_bi    = 8'h00;
                alu_ci    = alu_co;
                alu_bcd   = 1'b0;
                alu_rdy   = 1'b1;
            end
            ST_RORL: begin
                alu_op    = OP_ROR;
                alu_right = 1'b1;
                alu_ai    = ml_r;
                alu_bi    = 8'h00;
                alu_ci    = alu_co;
                alu_bcd   = 1'b0;
                alu_rdy   = 1'b1;
            end
            ST_NEXT, ST_DONE: begin
                alu_op    = OP_ROR;
                alu_right = 1'b1;
                alu_ai    = hold_ai_r;
                alu_bi    = 8'h00;
                alu_ci    = hold_ci_r;
                alu_bcd   = 1'b0;
                alu_rdy   = 1'b0;
            end
            default: begin
                alu_op    = cpu_op;
                alu_right = cpu_right;
                alu_ai    = cpu_ai;
                alu_bi    = cpu_bi;
                alu_ci    = cpu_ci;
                alu_bcd   = cpu_bcd;
                alu_rdy   = cpu_rdy;
            end
        endcase
    end

    assign prod  = prod_r;
    assign done  = done_r;
    assign busy  = busy_r;
    assign stall = busy_r;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: registered ALU model, phase-based reference model,
// directed cases from the test plan plus randomized start/operand/reset traffic.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] prod;
    logic        done, busy, stall;
    logic [3:0]  cpu_op;
    logic        cpu_right, cpu_ci, cpu_bcd, cpu_rdy;
    logic [7:0]  cpu_ai, cpu_bi;
    logic [3:0]  alu_op;
    logic        alu_right, alu_ci, alu_bcd, alu_rdy;
    logic [7:0]  alu_ai, alu_bi;
    logic [7:0]  alu_out = 8'h00;
    logic        alu_co = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: phase 0 = idle, 1..32 = iterations, 33 = DONE cycle
    int          m_phase = 0;
    logic [15:0] m_a = 16'h0, m_b = 16'h0, m_prod = 16'h0;
    bit          cpu_fixed = 1'b0;
    int          done_count;

    always #5 clk = ~clk;

    mul_seq dut (
        .clk(clk), .reset(reset), .start(start), .mul_a(mul_a), .mul_b(mul_b),
        .prod(prod), .done(done), .busy(busy), .stall(stall),
        .cpu_op(cpu_op), .cpu_right(cpu_right), .cpu_ai(cpu_ai), .cpu_bi(cpu_bi),
        .cpu_ci(cpu_ci), .cpu_bcd(cpu_bcd), .cpu_rdy(cpu_rdy),
        .alu_op(alu_op), .alu_right(alu_right), .alu_ai(alu_ai), .alu_bi(alu_bi),
        .alu_ci(alu_ci), .alu_bcd(alu_bcd), .alu_rdy(alu_rdy),
        .alu_out(alu_out), .alu_co(alu_co)
    );

    // shared ALU: registered result, one cycle after inputs presented with rdy
    always @(posedge clk) begin
        if (alu_rdy) begin
            if (alu_op == 4'b0011 && !alu_right) begin
                {alu_co, alu_out} <= {1'b0, alu_ai} + {1'b0, alu_bi} + {8'h00, alu_ci};
            end else if (alu_op == 4'b1111 && alu_right) begin
                alu_out <= {alu_ci, alu_ai[7:1]};
                alu_co  <= alu_ai[0];
            end else begin
                alu_out <= alu_ai ^ alu_bi;
                alu_co  <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int k;
        logic [15:0] part;
        chk("busy", {31'd0, busy}, (m_phase != 0) ? 32'd1 : 32'd0);
        chk("stall", {31'd0, stall}, (m_phase != 0) ? 32'd1 : 32'd0);
        chk("done", {31'd0, done}, (m_phase == 33) ? 32'd1 : 32'd0);
        chk("prod", {16'd0, prod}, {16'd0, m_prod});
        if (m_phase == 0) begin
            chk("passthrough",
                {9'd0, alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy},
                {9'd0, cpu_op, cpu_right, cpu_ai, cpu_bi, cpu_ci, cpu_bcd, cpu_rdy});
        end else begin
            chk("busy_bcd", {31'd0, alu_bcd}, 32'd0);
            chk("busy_rdy", {31'd0, alu_rdy},
                (m_phase <= 32 && ((m_phase - 1) % 4) != 3) ? 32'd1 : 32'd0);
            if (m_phase <= 32 && ((m_phase - 1) % 4) == 0) begin
                k = (m_phase - 1) / 4;
                // accumulator after k steps = high part of a * (low k bits of b), shifted by k
                part = (m_a * (m_b & ((16'd1 << k) - 16'd1))) >> k;
                chk("add_ctl", {26'd0, alu_op, alu_right, alu_ci}, {26'd0, 4'b0011, 1'b0, 1'b0});
                chk("add_ai", {24'd0, alu_ai}, {24'd0, part[7:0]});
                chk("add_bi", {24'd0, alu_bi}, m_b[k] ? {24'd0, m_a[7:0]} : 32'd0);
            end else begin
                chk("ror_ctl", {19'd0, alu_op, alu_right, alu_bi}, {19'd0, 4'b1111, 1'b1, 8'h00});
            end
        end
    endtask

    // one clock: drive at negedge, check, then advance the model across the next posedge
    task automatic step_cycle(input logic s, input logic [7:0] a, input logic [7:0] b, input logic r);
        @(negedge clk);
        reset = r;
        start = s;
        mul_a = a;
        mul_b = b;
        if (!cpu_fixed) begin
            cpu_op    = 4'($urandom);
            cpu_right = 1'($urandom);
            cpu_ai    = 8'($urandom);
            cpu_bi    = 8'($urandom);
            cpu_ci    = 1'($urandom);
            cpu_bcd   = 1'($urandom);
            cpu_rdy   = 1'($urandom);
        end
        if (r) begin
            m_phase = 0;
            m_prod  = 16'h0000;
        end
        #1;
        check_outputs();
        if (done) done_count++;
        if (!r) begin
            if (m_phase == 0) begin
                if (s) begin
                    m_phase = 1;
                    m_a = {8'h00, a};
                    m_b = {8'h00, b};
                end
            end else if (m_phase == 32) begin
                m_phase = 33;
                m_prod  = m_a * m_b;
            end else if (m_phase == 33) begin
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string name);
        int lat;
        lat = 41;
        step_cycle(1'b1, a, b, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            step_cycle(1'b0, 8'h00, 8'h00, 1'b0);
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({name, "_latency"}, lat, 32'd33);
        chk(name, {16'd0, prod}, {16'd0, exp});
        step_cycle(1'b0, 8'h00, 8'h00, 1'b0);
        chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mul_a = 8'h00; mul_b = 8'h00;
        cpu_op = 4'h0; cpu_right = 1'b0; cpu_ai = 8'h00; cpu_bi = 8'h00;
        cpu_ci = 1'b0; cpu_bcd = 1'b0; cpu_rdy = 1'b0;
        done_count = 0;

        step_cycle(1'b0, 8'h00, 8'h00, 1'b1);
        step_cycle(1'b0, 8'h00, 8'h00, 1'b1);
        chk("reset_prod", {16'd0, prod}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        step_cycle(1'b0, 8'h00, 8'h00, 1'b0);

        run_op(8'hFF, 8'hFF, 16'hFE01, "max");
        run_op(8'h0D, 8'h0B, 16'h008F, "mixed");
        run_op(8'h80, 8'h02, 16'h0100, "carry");
        run_op(8'h00, 8'hA5, 16'h0000, "zero");
        run_op(8'h01, 8'hA5, 16'h00A5, "identity");
        for (int i = 0; i < 5; i++) step_cycle(1'b0, 8'h00, 8'h00, 1'b0);
        chk("prod_hold", {16'd0, prod}, 32'h00A5);

        // second start while busy must be ignored
        done_count = 0;
        step_cycle(1'b1, 8'h12, 8'h34, 1'b0);
        for (int i = 1; i <= 45; i++) step_cycle(i == 10, 8'h77, 8'h99, 1'b0);
        chk("busy_start_dones", done_count, 32'd1);
        chk("busy_start_prod", {16'd0, prod}, 32'h03A8);

        // reset in the middle of an operation
        step_cycle(1'b1, 8'hFF, 8'hFF, 1'b0);
        for (int i = 1; i < 15; i++) step_cycle(1'b0, 8'h00, 8'h00, 1'b0);
        step_cycle(1'b0, 8'h00, 8'h00, 1'b1);
        chk("midrst_prod", {16'd0, prod}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        done_count = 0;
        for (int i = 0; i < 40; i++) step_cycle(1'b0, 8'h00, 8'h00, 1'b0);
        chk("midrst_no_done", done_count, 32'd0);
        run_op(8'h03, 8'h04, 16'h000C, "after_reset");

        // fixed core controls: idle mirror, then busy override
        cpu_fixed = 1'b1;
        cpu_op = 4'b0111; cpu_right = 1'b0; cpu_ai = 8'h50; cpu_bi = 8'h10;
        cpu_ci = 1'b0; cpu_bcd = 1'b1; cpu_rdy = 1'b0;
        step_cycle(1'b0, 8'h00, 8'h00, 1'b0);
        chk("pt_op", {28'd0, alu_op}, 32'h7);
        chk("pt_ai", {24'd0, alu_ai}, 32'h50);
        chk("pt_bi", {24'd0, alu_bi}, 32'h10);
        chk("pt_rdy", {31'd0, alu_rdy}, 32'd0);
        run_op(8'h0F, 8'h11, 16'h00FF, "fixed_cpu");
        cpu_fixed = 1'b0;

        // start held high: back-to-back launches every 34 cycles
        done_count = 0;
        for (int i = 0; i < 102; i++) step_cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0);
        chk("held_start_dones", done_count, 32'd3);

        // randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++)
            step_cycle($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom),
                       $urandom_range(0, 699) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
